// File: rtl/seq_mult_core_if.sv
// Operand/result handshake bundle for seq_mult_core.
// The master issues start and the operands. The slave returns busy, done and the product.
interface seq_mult_core_if #(parameter int WIDTH = 8);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, signed_mode, a, b, input busy, done, product);
  modport slave  (input start, signed_mode, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_core.sv
// Sequential shift-add multiplier that retires one multiplier bit per cycle.
// Signed operands are multiplied as magnitudes, and the sign is applied in the FIX state.
module seq_mult_core #(
  parameter int WIDTH = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  seq_mult_core_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH:0]     acc;
  logic                 neg;
  logic                 busy_q, done_q;
  logic [2*WIDTH-1:0]   product_q;
  logic [WIDTH:0]       upper_sum;
  logic [2*WIDTH:0]     acc_step;
  logic [2*WIDTH-1:0]   prod_abs;

  // The magnitude is taken in WIDTH unsigned bits, so the most negative value maps onto itself.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sm);
    return (sm && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // acc[WIDTH-1:0] starts out holding the multiplier. Partial sums build up in the upper half.
  always_comb begin
    upper_sum = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mcand}) : acc[2*WIDTH:WIDTH];
    acc_step  = {1'b0, upper_sum, acc[WIDTH-1:1]};
    prod_abs  = acc[2*WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = CALC;
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          mcand  <= mag(bus.a, bus.signed_mode);
          acc    <= {{(WIDTH+1){1'b0}}, mag(bus.b, bus.signed_mode)};
          neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          cnt    <= '0;
          busy_q <= 1'b1;
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          product_q <= neg ? (~prod_abs + (2*WIDTH)'(1)) : prod_abs;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule
